shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that sequences shift operations (SLL/SRL/SRA, register or immediate amount) through a narrow per-cycle step shifter instead of a full 32-bit barrel shifter. It sits beside the EX-stage ALU: the pipeline issues a shift request through a valid/ready handshake, holds EX while `busy` is high, and collects the result through a second handshake. `flush` kills an in-flight operation when the pipeline squashes the instruction.

## Interface
- `STEP`, default 8: maximum bit positions shifted per cycle; must be a power of two, 1..32.
- `clk` input 1: clock; every register updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous abort of any operation in progress.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `a` input 32: operand to be shifted.
- `b` input 32: register shift amount; only `b[4:0]` is used.
- `shamt` input 5: immediate shift amount.
- `ALUsrc` input 1: 1 selects `shamt`, 0 selects `b[4:0]`.
- `type` input 2: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
- `resp_valid` output 1: result present on `r`.
- `resp_ready` input 1: consumer accepts the result.
- `r` output 32: shift result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `a` into `acc`, latch `type`, and set `rem` = (`ALUsrc` ? `shamt` : `b[4:0]`).
  - For type 11, force `rem`=0.
  - Next state is SHIFT if `rem`≠0, else DONE.
- SHIFT:
  - Each cycle, `step` = min(`rem`, `STEP`).
  - SLL: `acc` <= `acc << step`.
  - SRL: `acc` <= `acc >> step`.
  - SRA: `acc` <= `$signed(acc) >>> step`, with the sign replicated on every step.
  - `rem` <= `rem` − `step`.
  - Go to DONE when the updated `rem` is 0.
- DONE:
  - `resp_valid`=1 and `r`=`acc`.
  - `r` and `resp_valid` stay stable until `resp_ready`=1.
  - Return to IDLE on the cycle after the handshake.
- `r` equals `acc` in every state.
- Result matches a single-cycle shift by the full amount for every `a` and amount 0..31.
- `rem` width is 6 bits. `step` never exceeds `rem`, so `rem` never underflows.
- `req_ready` is asserted only in IDLE. The block never accepts a new request in the same cycle as a response handshake.
- `flush`: next state is IDLE and `acc`/`rem` clear to 0. Any response not yet accepted is dropped.
- Precedence: `rst` > `flush` > normal operation.
- If `flush` and `req_valid` are both high in IDLE, the request is not accepted.

## Timing
- Reset values:
  - state = IDLE, so `req_ready`=1.
  - `resp_valid`=0, `busy`=0.
  - `r`=0, `acc`=0, `rem`=0.
- Request accepted at edge T. Let N = ceil(amount/`STEP`); N=0 for amount 0 or type 11.
- `resp_valid` rises in cycle T+1+N.
- With `resp_ready` already high, `req_ready` is 1 again in cycle T+2+N.
- Throughput is one operation per N+2 cycles. With STEP=8 the worst case (amount 31) is 6 cycles.
- `busy` is registered: high from T+1 through the response-handshake cycle.
- Reset in mid-operation (SHIFT or DONE) gives reset values on the next edge. No response is produced.

## Structure
- Shared package `shift_pkg`:
  - type encodings `SH_SLL`=2'b00, `SH_SRL`=2'b01, `SH_SRA`=2'b10, `SH_PASS`=2'b11.
  - state enum {IDLE, SHIFT, DONE}.
  - a `STEP` default constant.
- One sub-module, `shift_step`: combinational; shifts 32-bit data by 0..`STEP` according to type. It is instantiated once, feeding `acc`.
- FSM, `rem` counter and handshake logic live in `shift_sequencer`.

## Test plan
- STEP=8, SLL, `a`=0x00000001, `shamt`=31, `ALUsrc`=1, accepted at T:
  - `resp_valid` first at T+5.
  - `r`=0x80000000.
  - `busy` high T+1..T+5.
- SRA, `a`=0x80000000, `b`=0xFFFFFF24, `ALUsrc`=0:
  - amount 4, N=1.
  - `r`=0xF8000000 at T+2.
  - Upper `b` bits are ignored.
- SRL, `a`=0xDEADBEEF, amount 0; separately type 11 with amount 9:
  - both give `r`=0xDEADBEEF with `resp_valid` at T+1.
- Backpressure:
  - SLL, `a`=0x0000000F, amount 4; hold `resp_ready`=0 for 3 cycles in DONE.
  - `r`=0x000000F0 and `resp_valid` stay stable.
  - `req_ready`=0 throughout.
  - IDLE resumes the cycle after `resp_ready`=1.
- Mid-operation abort:
  - Assert `flush` in SHIFT during a 31-bit shift: next cycle is IDLE, `resp_valid`=0, `busy`=0.
  - Repeat with `rst` in DONE: all outputs at reset values.
- Randomised sweep, STEP ∈ {1, 4, 8, 32}:
  - all types, amounts 0..31, random `a`.
  - Every `r` matches a reference single-cycle shift.
  - Latency equals 1+N.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: shift types, FSM states
// and the default per-cycle step width.
package shift_pkg;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_PASS = 2'b11;

  localparam int STEP_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Narrow combinational shifter: moves 32-bit data by 0..STEP positions per call,
// sign-filling for SRA and passing data through for the pass-through type.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic [31:0]                  data_i,
  input  logic [$clog2(STEP + 1)-1:0] amt_i,
  input  logic [1:0]                   type_i,
  output logic [31:0]                  data_o
);

  always_comb begin
    data_o = data_i;
    case (type_i)
      SH_SLL:  data_o = data_i << amt_i;
      SH_SRL:  data_o = data_i >> amt_i;
      SH_SRA:  data_o = 32'($signed(data_i) >>> amt_i);
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller: walks the shift amount down STEP bits per
// cycle through shift_step, with valid/ready handshakes on request and response.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic        ALUsrc,
  input  logic [1:0]  sh_type,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] r,
  output logic        busy
);

  localparam int         AW       = $clog2(STEP + 1);
  localparam logic [5:0] STEP_REM = 6'(STEP);

  state_e        state_q;
  logic [31:0]   acc_q;
  logic [5:0]    rem_q;
  logic [1:0]    type_q;

  logic [5:0]    rem_init_d;
  logic [5:0]    rem_d;
  logic [AW-1:0] step_d;
  logic [31:0]   acc_d;

  // Only the low five bits of the register amount are meaningful.
  logic unused_b;
  assign unused_b = ^b[31:5];

  always_comb begin
    rem_init_d = {1'b0, (ALUsrc ? shamt : b[4:0])};
    if (sh_type == SH_PASS) rem_init_d = '0;
  end

  assign step_d = (rem_q < STEP_REM) ? rem_q[AW-1:0] : AW'(STEP);
  assign rem_d  = rem_q - 6'(step_d);

  shift_step #(
    .STEP (STEP)
  ) u_step (
    .data_i (acc_q),
    .amt_i  (step_d),
    .type_i (type_q),
    .data_o (acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            acc_q   <= a;
            type_q  <= sh_type;
            rem_q   <= rem_init_d;
            state_q <= (rem_init_d == 6'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == 6'd0) state_q <= DONE;
        end
        DONE: begin
          // Hold the result until the consumer takes it.
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign r          = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: four instances (STEP 1/4/8/32) share stimulus; a
// cycle-level reference model is compared every cycle, plus directed literal checks.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int NI = 4;
  localparam int STEPS [NI] = '{1, 4, 8, 32};
  localparam int D8 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic        ALUsrc = 1'b0;
  logic [1:0]  sh_type = 2'b00;
  logic        resp_ready = 1'b1;

  logic        req_ready_w  [NI];
  logic        resp_valid_w [NI];
  logic        busy_w       [NI];
  logic [31:0] r_w          [NI];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // Reference model state, one slot per instance.
  bit          m_busy   [NI];
  bit          m_valid  [NI];
  bit          m_rknown [NI];
  int          m_left   [NI];
  logic [31:0] m_r      [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    shift_sequencer #(
      .STEP (STEPS[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready_w[g]),
      .a          (a),
      .b          (b),
      .shamt      (shamt),
      .ALUsrc     (ALUsrc),
      .sh_type    (sh_type),
      .resp_valid (resp_valid_w[g]),
      .resp_ready (resp_ready),
      .r          (r_w[g]),
      .busy       (busy_w[g])
    );
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s, input logic [1:0] t);
    logic [31:0] fill;
    fill = ~(32'hFFFF_FFFF >> s);
    case (t)
      SH_SLL:  return x << s;
      SH_SRL:  return x >> s;
      SH_SRA:  return (x >> s) | (x[31] ? fill : 32'h0);
      default: return x;
    endcase
  endfunction

  function automatic int n_cycles(input int amt, input logic [1:0] t, input int st);
    if (t == SH_PASS || amt == 0) return 0;
    return (amt + st - 1) / st;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst || flush) begin
        m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_left[i] = 0;
        m_r[i] = '0; m_rknown[i] = 1'b1;
      end else if (!m_busy[i]) begin
        if (req_valid) begin
          int amt, n;
          amt = ALUsrc ? int'(shamt) : int'(b[4:0]);
          n = n_cycles(amt, sh_type, STEPS[i]);
          m_r[i] = ref_shift(a, (sh_type == SH_PASS) ? 0 : amt, sh_type);
          m_left[i] = n;
          m_busy[i] = 1'b1;
          m_valid[i] = (n == 0);
          m_rknown[i] = (n == 0);
        end
      end else if (!m_valid[i]) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_valid[i] = 1'b1; m_rknown[i] = 1'b1;
        end
      end else if (resp_ready) begin
        m_busy[i] = 1'b0; m_valid[i] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("mdl_req_ready[%0d]", i), 32'(req_ready_w[i]), 32'(!m_busy[i]));
          check($sformatf("mdl_busy[%0d]", i), 32'(busy_w[i]), 32'(m_busy[i]));
          check($sformatf("mdl_resp_valid[%0d]", i), 32'(resp_valid_w[i]), 32'(m_valid[i]));
          if (m_rknown[i]) check($sformatf("mdl_r[%0d]", i), r_w[i], m_r[i]);
        end
      end
    end
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [4:0] ts,
                       input logic tsrc, input logic [1:0] tt);
    @(negedge clk);
    a = ta; b = tb; shamt = ts; ALUsrc = tsrc; sh_type = tt; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (resp_valid_w[D8]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < NI; i++) if (!req_ready_w[i]) ok = 1'b0;
      if (ok) break;
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] ra;
    logic src;
    fork
      monitor();
    join_none

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_req_ready", 32'(req_ready_w[i]), 32'd1);
      check("rst_busy", 32'(busy_w[i]), 32'd0);
      check("rst_resp_valid", 32'(resp_valid_w[i]), 32'd0);
      check("rst_r", r_w[i], 32'h0);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    // SLL 1 by 31 (immediate): five cycles to the response on STEP=8.
    wait_idle();
    issue(32'h1, 32'h0, 5'd31, 1'b1, SH_SLL);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("sll31_busy_c%0d", c), 32'(busy_w[D8]), 32'd1);
      check($sformatf("sll31_valid_c%0d", c), 32'(resp_valid_w[D8]), 32'(c == 5));
    end
    check("sll31_r", r_w[D8], 32'h8000_0000);
    @(negedge clk);
    check("sll31_idle_busy", 32'(busy_w[D8]), 32'd0);
    check("sll31_idle_ready", 32'(req_ready_w[D8]), 32'd1);

    // SRA by register amount; upper b bits ignored.
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FF24, 5'd0, 1'b0, SH_SRA);
    wait_resp(lat);
    check("sra4_lat", 32'(lat), 32'd2);
    check("sra4_r", r_w[D8], 32'hF800_0000);

    // Zero amount and pass-through both respond the cycle after acceptance.
    wait_idle();
    issue(32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, SH_SRL);
    wait_resp(lat);
    check("srl0_lat", 32'(lat), 32'd1);
    check("srl0_r", r_w[D8], 32'hDEAD_BEEF);
    wait_idle();
    issue(32'hDEAD_BEEF, 32'h0, 5'd9, 1'b1, SH_PASS);
    wait_resp(lat);
    check("pass_lat", 32'(lat), 32'd1);
    check("pass_r", r_w[D8], 32'hDEAD_BEEF);

    // Backpressure: result held for three extra cycles.
    wait_idle();
    resp_ready = 1'b0;
    issue(32'h0000_000F, 32'h0, 5'd4, 1'b1, SH_SLL);
    wait_resp(lat);
    check("bp_lat", 32'(lat), 32'd2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("bp_r_%0d", k), r_w[D8], 32'h0000_00F0);
      check($sformatf("bp_valid_%0d", k), 32'(resp_valid_w[D8]), 32'd1);
      check($sformatf("bp_ready_%0d", k), 32'(req_ready_w[D8]), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_ready", 32'(req_ready_w[D8]), 32'd1);
    check("bp_resume_busy", 32'(busy_w[D8]), 32'd0);

    // Flush during a 31-bit shift.
    wait_idle();
    issue(32'h1234_5678, 32'h0, 5'd31, 1'b1, SH_SRA);
    @(negedge clk);
    @(negedge clk);
    check("fl_busy_before", 32'(busy_w[D8]), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fl_ready", 32'(req_ready_w[D8]), 32'd1);
    check("fl_valid", 32'(resp_valid_w[D8]), 32'd0);
    check("fl_busy", 32'(busy_w[D8]), 32'd0);
    check("fl_r", r_w[D8], 32'h0);

    // Flush together with a request in IDLE: request ignored.
    @(negedge clk);
    a = 32'hFFFF_FFFF; shamt = 5'd3; ALUsrc = 1'b1; sh_type = SH_SLL;
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("flreq_busy", 32'(busy_w[D8]), 32'd0);
    check("flreq_r", r_w[D8], 32'h0);

    // Reset while a response is pending in DONE.
    wait_idle();
    resp_ready = 1'b0;
    issue(32'h0000_1234, 32'h0, 5'd4, 1'b1, SH_SLL);
    wait_resp(lat);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_r", r_w[D8], 32'h0001_2340);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rd_ready", 32'(req_ready_w[D8]), 32'd1);
    check("rd_valid", 32'(resp_valid_w[D8]), 32'd0);
    check("rd_busy", 32'(busy_w[D8]), 32'd0);
    check("rd_r0", r_w[D8], 32'h0);
    resp_ready = 1'b1;

    // Sweep: every type and amount, random operand and source select.
    for (int t = 0; t < 4; t++) begin
      for (int amt = 0; amt < 32; amt++) begin
        wait_idle();
        ra  = $urandom;
        src = 1'($urandom_range(0, 1));
        issue(ra, {27'($urandom), 5'(amt)}, src ? 5'(amt) : 5'($urandom), src, 2'(t));
      end
    end
    wait_idle();

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
